// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: one owner at a time via IDLE/BBUSY/BWAIT/BFREE,
// released by done/dly or reclaimed by a BBUSY watchdog.
module bus_rr_arbiter #(
   parameter int N        = 4,
   parameter int IDW      = $clog2(N),
   parameter int MAX_BUSY = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic           done,
   input  logic           dly,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           busy,
   output logic           timeout
);

   localparam int CW = $clog2(MAX_BUSY);
   localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BUSY - 1);
   localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

   typedef enum logic [1:0] {IDLE, BBUSY, BWAIT, BFREE} state_t;

   state_t         state, nxt_state;
   logic [IDW-1:0] last, nxt_id;
   logic [CW-1:0]  cnt;
   logic           arb_req, grant_new, expire, nxt_busy;

   // Rotate req so bit 0 is the index just after the previous owner, then
   // take the first set bit and map it back to an absolute index.
   function automatic logic [IDW-1:0] rr_pick(input logic [IDW-1:0] from,
                                              input logic [N-1:0]   r);
      logic [2*N-1:0] r2;
      logic [N-1:0]   rot;
      int             k;
      int             o;
      r2  = {r, r} >> (int'(from) + 1);
      rot = r2[N-1:0];
      k   = 0;
      for (int i = N - 1; i >= 0; i--)
         if (rot[i]) k = i;
      o = int'(from) + 1 + k;
      if (o >= N) o = o - N;
      return IDW'(o);
   endfunction

   assign arb_req   = |req;
   assign grant_new = (state == IDLE || state == BFREE) && arb_req;
   assign expire    = (state == BBUSY) && !done && (cnt == CNT_LAST);
   assign nxt_busy  = (nxt_state == BBUSY) || (nxt_state == BWAIT);

   always_comb begin
      nxt_state = state;
      nxt_id    = gnt_id;
      case (state)
         IDLE: begin
            if (arb_req) begin
               nxt_state = BBUSY;
               nxt_id    = rr_pick(last, req);
            end
         end
         BBUSY: begin
            if (done)        nxt_state = dly ? BWAIT : BFREE;
            else if (expire) nxt_state = BFREE;
         end
         BWAIT: begin
            if (!dly) nxt_state = BFREE;
         end
         BFREE: begin
            if (arb_req) begin
               nxt_state = BBUSY;
               nxt_id    = rr_pick(last, req);
            end else begin
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_id  <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
         cnt     <= '0;
         last    <= LAST_RST;
      end else begin
         state   <= nxt_state;
         gnt_id  <= nxt_id;
         busy    <= nxt_busy;
         gnt     <= nxt_busy ? ({{(N-1){1'b0}}, 1'b1} << nxt_id) : '0;
         timeout <= expire;
         if (grant_new) last <= nxt_id;
         // Every entry to BBUSY comes through a fresh arbitration.
         if (grant_new)            cnt <= '0;
         else if (state == BBUSY)  cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (N=4, MAX_BUSY=4): rotation table plus
// hand sequences for single grant, delayed release, watchdog and async reset.
module tb_bus_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done, dly;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy, timeout;

   int n_cmp = 0;
   int n_err = 0;

   bus_rr_arbiter #(.N(4), .IDW(2), .MAX_BUSY(4)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done), .dly(dly),
      .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       done;
      logic       dly;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
      logic       to;
   } vec_t;

   vec_t tv[11];

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_out(input string nm, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic t);
      logic [7:0] act, exp;
      act = {gnt, gnt_id, busy, timeout};
      exp = {g, id, b, t};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                  nm, act[7:4], act[3:2], act[1], act[0], g, id, b, t);
      end
   endtask

   initial begin
      // Rotation from reset: last=3 so owner order is 0,1,2,3,0 with BFREE gaps.
      tv[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      tv[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
      tv[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tv[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
      tv[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      tv[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
      tv[6]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
      tv[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
      tv[8]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      tv[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
      tv[10] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

      rst = 1'b1; req = '0; done = 1'b0; dly = 1'b0;
      repeat (2) @(negedge clk);
      expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Single grant then release
      req = 4'b0100; step();
      expect_out("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
      req = '0; done = 1'b1; step();
      expect_out("single_bfree", 4'b0000, 2'd2, 1'b0, 1'b0);
      done = 1'b0; step();
      expect_out("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

      rst = 1'b1; #1; rst = 1'b0;
      for (int i = 0; i < 11; i++) begin
         req = tv[i].req; done = tv[i].done; dly = tv[i].dly;
         step();
         expect_out($sformatf("rr_%0d", i), tv[i].gnt, tv[i].id, tv[i].busy, tv[i].to);
      end

      // Delayed release: BWAIT outlasts MAX_BUSY without a timeout
      req = 4'b0010; done = 1'b0; dly = 1'b0; step();
      expect_out("dly_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = '0; done = 1'b1; dly = 1'b1; step();
      expect_out("dly_wait_1", 4'b0010, 2'd1, 1'b1, 1'b0);
      done = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         step();
         expect_out($sformatf("dly_wait_%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      dly = 1'b0; step();
      expect_out("dly_free", 4'b0000, 2'd1, 1'b0, 1'b0);
      step();
      expect_out("dly_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

      // Watchdog: owner 1 never signals done
      req = 4'b0010; step();
      expect_out("wd_busy_1", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b0110;
      for (int k = 2; k <= 4; k++) begin
         step();
         expect_out($sformatf("wd_busy_%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      step();
      expect_out("wd_timeout", 4'b0000, 2'd1, 1'b0, 1'b1);
      step();
      expect_out("wd_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Done in the expiry cycle wins over the watchdog
      for (int k = 2; k <= 4; k++) begin
         step();
         expect_out($sformatf("exp_busy_%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
      end
      req = '0; done = 1'b1; step();
      expect_out("exp_done", 4'b0000, 2'd2, 1'b0, 1'b0);
      done = 1'b0; step();
      expect_out("exp_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

      // Async reset while in BWAIT
      req = 4'b1000; step();
      expect_out("ar_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
      req = '0; done = 1'b1; dly = 1'b1; step();
      expect_out("ar_bwait", 4'b1000, 2'd3, 1'b1, 1'b0);
      done = 1'b0;
      #2 rst = 1'b1;
      #1 expect_out("ar_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0; dly = 1'b0;
      @(negedge clk);
      req = 4'b1111; step();
      expect_out("ar_first", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = '0; done = 1'b1; step();
      expect_out("ar_release", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
